router_fifo: RTL and testbench
==============================

Name: router_fifo

Overview:
- Per-destination output buffer of the 1x3 router. Sits directly downstream of the register stage.
- Captures each byte that stage drives on its data bus while the controller asserts write enable. Tags the header byte using the controller's header-load state.
- Presents bytes to the destination client on read enable.
- Tracks packet length so the client sees an end-of-packet indication. Supports a soft reset from the synchroniser on client time-out.

Parameters:
- DEPTH, 16, number of 9-bit entries; power of two, minimum 4.
- ADDR_W, 4, log2(DEPTH); pointer width is ADDR_W+1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- soft_reset  input  1  synchronous flush from synchroniser (client time-out); active-high.
- write_enb  input  1  write request for this FIFO.
- lfd_state  input  1  controller in header-load state; tags the word written this cycle as header.
- data_in  input  8  byte from register stage.
- read_enb  input  1  read request from destination client.
- data_out  output  8  registered read data.
- data_valid  output  1  data_out holds a byte read on the previous cycle.
- pkt_end  output  1  one-cycle pulse with data_valid on the packet's parity byte.
- empty  output  1  no stored entries.
- full  output  1  DEPTH entries stored.

Behaviour:
- Storage: DEPTH x 9 array; bit 8 is the header tag, bits 7:0 are the data.
- Pointers: wr_ptr and rd_ptr are ADDR_W+1 bits wide. The low ADDR_W bits address the array and wrap modulo DEPTH.
  - empty = (wr_ptr == rd_ptr), combinational.
  - full = MSBs differ and low bits are equal, combinational.
- Write: when write_enb && !full, store {lfd_state, data_in} at wr_ptr and increment wr_ptr. Writes while full are dropped with no state change.
- Read: when read_enb && !empty, on the next edge data_out <= mem[rd_ptr][7:0] and data_valid <= 1, then rd_ptr increments. Read latency is 1 cycle.
  - Otherwise data_valid <= 0 and data_out holds its last value.
  - A read while empty is ignored.
- Simultaneous read and write:
  - Both proceed when permitted; occupancy is unchanged.
  - When full, the write is blocked and the read proceeds. The write is not retried.
  - When empty, the write proceeds and the read is ignored. There is no fall-through.
- Packet counter: pkt_cnt is 7 bits.
  - On a read of a header-tagged word, pkt_cnt <= data[7:2] + 1 (payload length plus parity byte).
  - On a read of an untagged word with pkt_cnt != 0, pkt_cnt decrements.
  - pkt_end <= 1 on the read that moves pkt_cnt from 1 to 0; otherwise pkt_end <= 0.
  - Reads of untagged words with pkt_cnt == 0 still output data, with no pkt_end and no underflow of the counter.
- Header length 0: pkt_cnt = 1, so the next byte read (the parity byte) raises pkt_end.
- soft_reset:
  - Clears wr_ptr, rd_ptr, pkt_cnt, data_valid and pkt_end. data_out <= 0.
  - Array contents are not cleared.
  - Has priority over any write or read in the same cycle.
- rst: same effect as soft_reset. rst has highest priority, including mid-packet.
- Reset values: data_out 0, data_valid 0, pkt_end 0, empty 1, full 0.

Optional Feature:
- Macro: ROUTER_FIFO_OVF_EN.
- When defined, two extra outputs are added:
  - overflow (1 bit): sticky; set on a write_enb while full.
  - underflow (1 bit): sticky; set on a read_enb while empty.
  - Both are cleared by rst or soft_reset. Both reset to 0.
  - If the setting condition and soft_reset occur in the same cycle, the clear wins.
- When not defined, both ports and their logic are absent. Dropped accesses are silent.

Test Plan:
- Header/packet: after rst, write header 0x0C with lfd_state=1, then payload 0x11,0x22,0x33 and parity 0x00. Read 5 times.
  - Required: data_out 0x0C,0x11,0x22,0x33,0x00, each one cycle after read_enb.
  - Required: pkt_end high only with 0x00; empty=1 after the last read.
- Full boundary: write 16 bytes with no reads.
  - Required: full=1 after the 16th write.
  - Then write a 17th byte 0xAA: dropped. Reading 16 bytes never returns 0xAA; overflow=1 when the feature is enabled.
- Concurrent access at full: with 16 stored, assert write_enb and read_enb in the same cycle.
  - Required: one byte read out, write dropped, full deasserts, occupancy becomes 15.
- Wrap-around: write 10 bytes, read 10 bytes, then write 10 bytes 0x40..0x49 and read them back.
  - Required: 0x40..0x49 returned in order; empty/full correct across the pointer wrap.
- Soft reset mid-packet: write header 0x14 plus 2 payload bytes, read 2 bytes, pulse soft_reset.
  - Required: next cycle empty=1, data_out=0x00, data_valid=0.
  - Required: a following 0-length packet (header 0x00, parity 0x5A) reads back with pkt_end on 0x5A.
- Empty read: read_enb with empty=1.
  - Required: data_valid stays 0, pointers unchanged, underflow=1 when the feature is enabled.

Source files
------------

// File: rtl/router_fifo.sv
// router_fifo: per-destination output buffer of the 1x3 router.
// Stores 9-bit entries ({header_tag, byte}) written by the register stage and
// hands bytes to the destination client with one cycle of read latency.
// While reading, it counts down the packet length taken from the header byte.
// It raises pkt_end alongside the parity byte.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   soft_reset        synchronous flush on client time-out
//   write_enb         write request; lfd_state tags the written byte as header
//   data_in[7:0]      byte from register stage
//   read_enb          read request from destination client
//   data_out[7:0]     registered read data
//   data_valid        data_out was read on the previous cycle
//   pkt_end           one-cycle pulse on the packet's parity byte
//   empty, full       occupancy flags (combinational)
//   overflow/underflow  sticky error flags, present only when
//                       ROUTER_FIFO_OVF_EN is defined
module router_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       soft_reset,
  input  logic       write_enb,
  input  logic       lfd_state,
  input  logic [7:0] data_in,
  input  logic       read_enb,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       pkt_end,
  output logic       empty,
  output logic       full
`ifdef ROUTER_FIFO_OVF_EN
  ,
  output logic       overflow,
  output logic       underflow
`endif
);

  logic [8:0]        mem [DEPTH];

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [6:0]        pkt_cnt_q, pkt_cnt_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              pkt_end_q, pkt_end_d;

  logic              do_wr, do_rd;
  logic [8:0]        rd_word;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  assign do_wr   = write_enb && !full && !soft_reset;
  assign do_rd   = read_enb && !empty && !soft_reset;
  assign rd_word = mem[rd_ptr_q[ADDR_W-1:0]];

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    pkt_cnt_d    = pkt_cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    pkt_end_d    = 1'b0;
    if (soft_reset) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      pkt_cnt_d  = '0;
      data_out_d = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) begin
        rd_ptr_d     = rd_ptr_q + 1'b1;
        data_out_d   = rd_word[7:0];
        data_valid_d = 1'b1;
        if (rd_word[8]) begin
          // Header: payload length field plus one for the parity byte.
          pkt_cnt_d = {1'b0, rd_word[7:2]} + 7'd1;
        end else if (pkt_cnt_q != '0) begin
          pkt_cnt_d = pkt_cnt_q - 7'd1;
          pkt_end_d = (pkt_cnt_q == 7'd1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pkt_cnt_q    <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      pkt_end_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_cnt_q    <= pkt_cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      pkt_end_q    <= pkt_end_d;
    end
  end

  // Array contents survive both resets; only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (!rst && do_wr) mem[wr_ptr_q[ADDR_W-1:0]] <= {lfd_state, data_in};
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign pkt_end    = pkt_end_q;

`ifdef ROUTER_FIFO_OVF_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (write_enb & full);
    underflow_d = underflow_q | (read_enb & empty);
    if (soft_reset) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo. A queue-based reference model tracks
// stored entries, remaining bytes of the current packet and sticky error flags.
module tb_router_fifo;

  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst, soft_reset, write_enb, lfd_state, read_enb;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_valid, pkt_end, empty, full;
`ifdef ROUTER_FIFO_OVF_EN
  logic       overflow, underflow;
`endif

  router_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .soft_reset(soft_reset),
    .write_enb(write_enb), .lfd_state(lfd_state), .data_in(data_in),
    .read_enb(read_enb), .data_out(data_out), .data_valid(data_valid),
    .pkt_end(pkt_end), .empty(empty), .full(full)
`ifdef ROUTER_FIFO_OVF_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [8:0] q[$];
  int         rem;
  logic [7:0] exp_dout;
  logic       exp_dv, exp_pe, exp_ovf, exp_unf;

  task automatic model_clear();
    q.delete();
    rem = 0; exp_dout = 8'h00; exp_dv = 1'b0; exp_pe = 1'b0;
    exp_ovf = 1'b0; exp_unf = 1'b0;
  endtask

  // Drive one clock cycle and advance the model; outputs are sampled 1 ns after the edge.
  task automatic cycle(input logic we, input logic lfd, input logic [7:0] din,
                       input logic re, input logic srst);
    logic [8:0] w;
    bit can_rd, can_wr;
    write_enb = we; lfd_state = lfd; data_in = din; read_enb = re; soft_reset = srst;
    can_rd = re && (q.size() != 0);
    can_wr = we && (q.size() < DEPTH);
    @(posedge clk);
    #1;
    if (srst) begin
      model_clear();
    end else begin
      if (we && q.size() == DEPTH) exp_ovf = 1'b1;
      if (re && q.size() == 0)     exp_unf = 1'b1;
      exp_pe = 1'b0;
      exp_dv = 1'b0;
      if (can_rd) begin
        w = q.pop_front();
        exp_dv = 1'b1;
        exp_dout = w[7:0];
        if (w[8]) rem = int'(w[7:2]) + 1;
        else if (rem > 0) begin
          rem--;
          exp_pe = (rem == 0);
        end
      end
      if (can_wr) q.push_back({lfd, din});
    end
    write_enb = 0; read_enb = 0; soft_reset = 0; lfd_state = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    n_checks++;
    if (data_out !== 8'h00 || data_valid !== 1'b0 || pkt_end !== 1'b0 ||
        empty !== 1'b1 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: dout=%h dv=%b pe=%b empty=%b full=%b, want 00 0 0 1 0",
               data_out, data_valid, pkt_end, empty, full);
    end
  endtask

  task automatic test_packet();
    logic [7:0] bytes [5];
    bytes[0] = 8'h0C; bytes[1] = 8'h11; bytes[2] = 8'h22; bytes[3] = 8'h33; bytes[4] = 8'h00;
    for (int i = 0; i < 5; i++) cycle(1'b1, i == 0, bytes[i], 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (data_out !== bytes[i] || data_valid !== 1'b1 || pkt_end !== (i == 4)) begin
        n_fail++;
        $display("FAIL packet[%0d]: dout=%h dv=%b pe=%b, want %h 1 %b",
                 i, data_out, data_valid, pkt_end, bytes[i], i == 4);
      end
    end
    n_checks++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL packet_empty: empty=%b, want 1", empty);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'($urandom_range(0, 127)), 1'b0, 1'b0);
    n_checks++;
    if (full !== 1'b1 || empty !== 1'b0) begin
      n_fail++;
      $display("FAIL full_flag: full=%b empty=%b, want 1 0", full, empty);
    end
    cycle(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
    n_checks++;
    if (full !== 1'b1) begin
      n_fail++;
      $display("FAIL full_after_drop: full=%b, want 1", full);
    end
`ifdef ROUTER_FIFO_OVF_EN
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: got %b, want 1", overflow);
    end
`endif
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (data_out === 8'hAA || data_out !== exp_dout || data_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL full_drain[%0d]: dout=%h dv=%b, want %h 1", i, data_out, data_valid, exp_dout);
      end
    end
    n_checks++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL full_drain_empty: empty=%b, want 1", empty);
    end
  endtask

  task automatic test_concurrent_full();
    int got;
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(8'h60 + i), 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'hEE, 1'b1, 1'b0);
    n_checks++;
    if (data_valid !== 1'b1 || data_out !== 8'h60 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL concurrent_full: dv=%b dout=%h full=%b, want 1 60 0", data_valid, data_out, full);
    end
    got = 0;
    for (int i = 0; i < 20 && empty !== 1'b1; i++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      if (data_valid === 1'b1) got++;
    end
    n_checks++;
    if (got != 15) begin
      n_fail++;
      $display("FAIL concurrent_occupancy: got %0d, want 15", got);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 8'(8'h40 + i), 1'b0, 1'b0);
      n_checks++;
      if (empty !== 1'b0 || full !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_flags_wr[%0d]: empty=%b full=%b, want 0 0", i, empty, full);
      end
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (data_out !== 8'(8'h40 + i) || data_valid !== 1'b1 || empty !== (i == 9)) begin
        n_fail++;
        $display("FAIL wrap_read[%0d]: dout=%h dv=%b empty=%b, want %h 1 %b",
                 i, data_out, data_valid, empty, 8'(8'h40 + i), i == 9);
      end
    end
  endtask

  task automatic test_soft_reset();
    cycle(1'b1, 1'b1, 8'h14, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'hA1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'hA2, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 8'h77, 1'b1, 1'b1);
    n_checks++;
    if (empty !== 1'b1 || data_out !== 8'h00 || data_valid !== 1'b0 || pkt_end !== 1'b0) begin
      n_fail++;
      $display("FAIL soft_reset: empty=%b dout=%h dv=%b pe=%b, want 1 00 0 0",
               empty, data_out, data_valid, pkt_end);
    end
    cycle(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (data_out !== 8'h00 || data_valid !== 1'b1 || pkt_end !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len_hdr: dout=%h dv=%b pe=%b, want 00 1 0", data_out, data_valid, pkt_end);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (data_out !== 8'h5A || data_valid !== 1'b1 || pkt_end !== 1'b1 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_len_parity: dout=%h dv=%b pe=%b empty=%b, want 5A 1 1 1",
               data_out, data_valid, pkt_end, empty);
    end
  endtask

  task automatic test_empty_read();
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (data_valid !== 1'b0 || empty !== 1'b1 || data_out !== 8'h5A) begin
      n_fail++;
      $display("FAIL empty_read: dv=%b empty=%b dout=%h, want 0 1 5A", data_valid, empty, data_out);
    end
`ifdef ROUTER_FIFO_OVF_EN
    n_checks++;
    if (underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow: got %b, want 1", underflow);
    end
`endif
    cycle(1'b1, 1'b0, 8'hC3, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (data_out !== 8'hC3 || data_valid !== 1'b1 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_read_ptrs: dout=%h dv=%b empty=%b, want C3 1 1", data_out, data_valid, empty);
    end
  endtask

  task automatic test_random();
    logic we, re, lfd, sr;
    for (int i = 0; i < 400; i++) begin
      we  = ($urandom_range(0, 9) < 6);
      re  = ($urandom_range(0, 9) < 5);
      lfd = ($urandom_range(0, 9) == 0);
      sr  = ($urandom_range(0, 49) == 0);
      cycle(we, lfd, 8'($urandom_range(0, 255)), re, sr);
      n_checks++;
      if (data_out !== exp_dout || data_valid !== exp_dv || pkt_end !== exp_pe ||
          empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin
        n_fail++;
        $display("FAIL random[%0d]: dout=%h dv=%b pe=%b empty=%b full=%b, want %h %b %b %b %b",
                 i, data_out, data_valid, pkt_end, empty, full,
                 exp_dout, exp_dv, exp_pe, q.size() == 0, q.size() == DEPTH);
      end
`ifdef ROUTER_FIFO_OVF_EN
      n_checks++;
      if (overflow !== exp_ovf || underflow !== exp_unf) begin
        n_fail++;
        $display("FAIL random_flags[%0d]: ovf=%b unf=%b, want %b %b",
                 i, overflow, underflow, exp_ovf, exp_unf);
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; soft_reset = 1'b0; write_enb = 1'b0; lfd_state = 1'b0;
    read_enb = 1'b0; data_in = 8'h00;
    model_clear();
    test_reset();
    test_packet();
    test_full();
    test_concurrent_full();
    test_wrap();
    test_soft_reset();
    test_empty_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
